// File: rtl/axis_byte_packer.sv
// -----------------------------------------------------------------------------
// axis_byte_packer
//
// Registered AXI-Stream byte packer. Sparse or partially filled input beats are
// merged into dense, left-aligned output beats. Bytes that do not fill a whole
// output beat are carried in a residue register until more bytes arrive or the
// packet ends; a packet whose last beat overflows the output width takes one
// extra flush cycle to emit its tail.
//
// Byte ordering: byte DATA_BYTE_WD-1 (the MSB lane) is the first byte of a beat,
// and keep bit DATA_BYTE_WD-1 belongs to it.
//
// Configuration macro: AXIS_PACKER_SPARSE_KEEP_EN
//   defined   : any keep_in pattern is legal; enabled bytes are compacted
//               MSB-first before packing; keep_err is always 0.
//   undefined : keep_in is expected to be MSB-contiguous. The top popcount
//               bytes of data_in are taken as-is; a non-contiguous pattern
//               raises a one-cycle keep_err pulse.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   valid_in   in   upstream beat valid
//   data_in    in   upstream data (DATA_WD)
//   keep_in    in   upstream byte enables (DATA_BYTE_WD)
//   last_in    in   last beat of packet
//   ready_in   out  upstream ready (combinational from state and ready_out)
//   valid_out  out  output beat valid
//   data_out   out  packed, left-aligned data, unused bytes zero
//   keep_out   out  MSB-contiguous byte enables
//   last_out   out  last beat of packet
//   ready_out  in   downstream ready
//   keep_err   out  one-cycle pulse after an illegal keep_in is accepted
// -----------------------------------------------------------------------------
module axis_byte_packer #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    keep_err
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam int TW = BYTE_CNT_WD + 2;
  localparam logic [TW-1:0] FULL_CNT = TW'(DATA_BYTE_WD);

  typedef enum logic [0:0] {
    S_ACC   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WD-1:0]      res_data, res_data_nxt;
  logic [CW-1:0]           res_cnt, res_cnt_nxt;
  logic                    valid_out_nxt;
  logic [DATA_WD-1:0]      data_out_nxt;
  logic [DATA_BYTE_WD-1:0] keep_out_nxt;
  logic                    last_out_nxt;
  logic                    keep_err_nxt;

  logic [CW-1:0]           n;
  logic [TW-1:0]           total;
  logic [DATA_WD-1:0]      in_packed;
  logic [2*DATA_WD-1:0]    merged;
  logic                    keep_bad;
  logic                    slot_free;
  logic                    accept;

  // Top k keep bits set; k == DATA_BYTE_WD shifts everything out, giving all ones.
  function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [TW-1:0] k);
    return ~({DATA_BYTE_WD{1'b1}} >> k);
  endfunction

  assign slot_free = !valid_out || ready_out;
  assign ready_in  = (state == S_ACC) && slot_free;
  assign accept    = valid_in && ready_in;

  always_comb begin
    n = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      n = n + CW'(keep_in[i]);
    end
  end

  assign total = TW'(res_cnt) + TW'(n);

`ifdef AXIS_PACKER_SPARSE_KEEP_EN
  // Compact enabled bytes towards the MSB lane, skipping holes.
  always_comb begin
    logic [CW-1:0] pos;
    in_packed = '0;
    pos       = '0;
    for (int i = DATA_BYTE_WD - 1; i >= 0; i--) begin
      if (keep_in[i]) begin
        in_packed[(DATA_BYTE_WD - 1 - int'(pos)) * 8 +: 8] = data_in[i * 8 +: 8];
        pos = pos + CW'(1);
      end
    end
  end

  assign keep_bad = 1'b0;
`else
  logic [DATA_BYTE_WD-1:0] n_mask;

  // Take the top n lanes as-is; a legal keep equals exactly that mask.
  always_comb begin
    n_mask    = top_mask(TW'(n));
    in_packed = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      in_packed[i * 8 +: 8] = n_mask[i] ? data_in[i * 8 +: 8] : 8'h00;
    end
  end

  assign keep_bad = (keep_in != n_mask);
`endif

  // Residue bytes first, then the new bytes right behind them. Both sources
  // are zero past their valid bytes, so an OR is a clean concatenation.
  assign merged = {res_data, {DATA_WD{1'b0}}}
                | ({in_packed, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});

  always_comb begin
    state_nxt     = state;
    res_data_nxt  = res_data;
    res_cnt_nxt   = res_cnt;
    valid_out_nxt = valid_out && !ready_out;
    data_out_nxt  = data_out;
    keep_out_nxt  = keep_out;
    last_out_nxt  = last_out;
    keep_err_nxt  = 1'b0;

    case (state)
      S_ACC: begin
        if (accept) begin
          keep_err_nxt = keep_bad;
          if (total < FULL_CNT) begin
            if (last_in) begin
              // Also covers an empty last beat: keep_out=0 still marks the boundary.
              valid_out_nxt = 1'b1;
              data_out_nxt  = merged[2*DATA_WD-1:DATA_WD];
              keep_out_nxt  = top_mask(total);
              last_out_nxt  = 1'b1;
              res_data_nxt  = '0;
              res_cnt_nxt   = '0;
            end else begin
              res_data_nxt = merged[2*DATA_WD-1:DATA_WD];
              res_cnt_nxt  = CW'(total);
            end
          end else if (total == FULL_CNT) begin
            valid_out_nxt = 1'b1;
            data_out_nxt  = merged[2*DATA_WD-1:DATA_WD];
            keep_out_nxt  = '1;
            last_out_nxt  = last_in;
            res_data_nxt  = '0;
            res_cnt_nxt   = '0;
          end else begin
            // Overflow: the tail is already left-aligned in the lower half.
            valid_out_nxt = 1'b1;
            data_out_nxt  = merged[2*DATA_WD-1:DATA_WD];
            keep_out_nxt  = '1;
            last_out_nxt  = 1'b0;
            res_data_nxt  = merged[DATA_WD-1:0];
            res_cnt_nxt   = CW'(total - FULL_CNT);
            if (last_in) begin
              state_nxt = S_FLUSH;
            end
          end
        end
      end

      S_FLUSH: begin
        if (slot_free) begin
          valid_out_nxt = 1'b1;
          data_out_nxt  = res_data;
          keep_out_nxt  = top_mask(TW'(res_cnt));
          last_out_nxt  = 1'b1;
          res_data_nxt  = '0;
          res_cnt_nxt   = '0;
          state_nxt     = S_ACC;
        end
      end

      default: begin
        state_nxt = S_ACC;
      end
    endcase
  end

  // A reset drops residue and any pending output beat without flushing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      res_data  <= '0;
      res_cnt   <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
      keep_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      res_data  <= res_data_nxt;
      res_cnt   <= res_cnt_nxt;
      valid_out <= valid_out_nxt;
      data_out  <= data_out_nxt;
      keep_out  <= keep_out_nxt;
      last_out  <= last_out_nxt;
      keep_err  <= keep_err_nxt;
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_byte_packer
//
// Scoreboard bench for axis_byte_packer (DATA_WD=32). Accepted input beats feed
// a byte-queue reference model that pushes expected output beats; a monitor
// pops and compares every output transfer, and also watches output stability
// under back-pressure. Honors AXIS_PACKER_SPARSE_KEEP_EN the same way the DUT
// build does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_byte_packer;

  localparam int DW = 32;
  localparam int NB = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [NB-1:0] keep_in = '0;
  logic          last_in = 1'b0;
  logic          ready_out = 1'b1;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [NB-1:0] keep_out;
  logic          last_out;
  logic          keep_err;

  int total_cnt = 0;
  int bad_cnt   = 0;

  beat_t      exp_q[$];
  logic [7:0] byte_q[$];
  logic       pend_err = 1'b0;
  bit         rand_ready = 1'b0;

  logic          hold = 1'b0;
  logic [DW-1:0] hold_data;
  logic [NB-1:0] hold_keep;
  logic          hold_last;

  axis_byte_packer #(.DATA_WD(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .keep_in   (keep_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out),
    .ready_out (ready_out),
    .keep_err  (keep_err)
  );

  always #5 clk = ~clk;

  task checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit contiguous(input logic [NB-1:0] k);
    bit seen_zero = 1'b0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (!k[i]) seen_zero = 1'b1;
      else if (seen_zero) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Pop k bytes off the packet byte stream into one expected output beat.
  task automatic push_beat(input int k, input logic l);
    beat_t b;
    b.data = '0;
    b.keep = '0;
    b.last = l;
    for (int i = 0; i < k; i++) begin
      b.data[(NB - 1 - i) * 8 +: 8] = byte_q.pop_front();
      b.keep[NB - 1 - i] = 1'b1;
    end
    exp_q.push_back(b);
  endtask

  // Reference: the packet is a byte stream; every full group of NB bytes is a
  // beat, and the end of the packet emits whatever is left (even nothing).
  task automatic model_accept(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    int  cnt = 0;
    bit  last_done = 1'b0;
    for (int i = 0; i < NB; i++) cnt += int'(k[i]);
`ifdef AXIS_PACKER_SPARSE_KEEP_EN
    for (int i = NB - 1; i >= 0; i--) begin
      if (k[i]) byte_q.push_back(d[i * 8 +: 8]);
    end
`else
    for (int i = 0; i < cnt; i++) byte_q.push_back(d[(NB - 1 - i) * 8 +: 8]);
`endif
    if (byte_q.size() >= NB) begin
      last_done = l && (byte_q.size() == NB);
      push_beat(NB, last_done);
    end
    if (l && !last_done) push_beat(byte_q.size(), 1'b1);
  endtask

  // Scoreboard producer: model accepted beats and predict keep_err.
  always @(negedge clk) begin
    if (rst) begin
      byte_q.delete();
      exp_q.delete();
      pend_err = 1'b0;
    end else begin
      checkOutput("keep_err", keep_err, pend_err);
      pend_err = 1'b0;
      if (valid_in && ready_in) begin
`ifndef AXIS_PACKER_SPARSE_KEEP_EN
        pend_err = !contiguous(keep_in);
`endif
        model_accept(data_in, keep_in, last_in);
      end
    end
  end

  // Monitor: compare each output transfer and check stability while stalled.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        checkOutput("hold_stable", {valid_out, last_out, keep_out, data_out},
                    {1'b1, hold_last, hold_keep, hold_data});
      end
      if (valid_out && !ready_out) checkOutput("ready_in_stalled", ready_in, 1'b0);
      if (valid_out && ready_out) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          bad_cnt++;
          $display("[TB] FAIL unexpected_beat: got data %0h keep %0h last %0b with nothing expected",
                   data_out, keep_out, last_out);
        end else begin
          b = exp_q.pop_front();
          checkOutput("data_out", data_out, b.data);
          checkOutput("keep_out", keep_out, b.keep);
          checkOutput("last_out", last_out, b.last);
        end
      end
      hold      = valid_out && !ready_out;
      hold_data = data_out;
      hold_keep = keep_out;
      hold_last = last_out;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) ready_out = ($urandom_range(0, 9) < 7);
  end

  // Present one beat and wait (bounded) until it is taken.
  task applyStimulus(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    int waited = 0;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    valid_in = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_in) break;
      waited++;
      if (waited > 200) begin
        total_cnt++;
        bad_cnt++;
        $display("[TB] FAIL accept_timeout: ready_in stayed %0b for %0d cycles", ready_in, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  initial begin
    logic [NB-1:0] k;
    int            cnt;
    int            waited;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_outputs", {valid_out, last_out, keep_err, keep_out, data_out}, 64'h0);
    checkOutput("reset_ready_in", ready_in, 1'b1);

    // 3 + 3 + 2(last) bytes pack into two full beats.
    applyStimulus(32'hAABBCC00, 4'b1110, 1'b0);
    applyStimulus(32'hDDEEFF00, 4'b1110, 1'b0);
    checkOutput("plan1_beat0", {keep_out, data_out}, {4'b1111, 32'hAABBCCDD});
    applyStimulus(32'h11220000, 4'b1100, 1'b1);
    checkOutput("plan1_beat1", {last_out, keep_out, data_out}, {1'b1, 4'b1111, 32'hEEFF1122});

    // Overflow on the last beat needs a flush cycle.
    applyStimulus(32'hAABBCC00, 4'b1110, 1'b0);
    applyStimulus(32'hDDEEFF00, 4'b1110, 1'b1);
    checkOutput("flush_ready_in", ready_in, 1'b0);
    checkOutput("flush_beat0", {last_out, keep_out, data_out}, {1'b0, 4'b1111, 32'hAABBCCDD});
    @(posedge clk);
    #1;
    checkOutput("flush_beat1", {last_out, keep_out, data_out}, {1'b1, 4'b1100, 32'hEEFF0000});
    checkOutput("flush_done_ready_in", ready_in, 1'b1);

    // Back-pressure with a beat pending and another waiting upstream.
    applyStimulus(32'h01020304, 4'b1111, 1'b1);
    ready_out = 1'b0;
    data_in   = 32'h0A0B0C00;
    keep_in   = 4'b1110;
    last_in   = 1'b1;
    valid_in  = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("bp_ready_in", ready_in, 1'b0);
      checkOutput("bp_beat", {valid_out, data_out}, {1'b1, 32'h01020304});
    end
    ready_out = 1'b1;
    applyStimulus(32'h0A0B0C00, 4'b1110, 1'b1);
    checkOutput("bp_release", {last_out, keep_out, data_out}, {1'b1, 4'b1110, 32'h0A0B0C00});

    // Empty last beat still marks the packet boundary.
    applyStimulus(32'h0, 4'b0000, 1'b1);
    checkOutput("empty_beat", {valid_out, last_out, keep_out}, {1'b1, 1'b1, 4'b0000});

    // Holes in keep.
    applyStimulus(32'hAA11BB22, 4'b1010, 1'b1);
`ifdef AXIS_PACKER_SPARSE_KEEP_EN
    checkOutput("sparse_data", {keep_out, data_out}, {4'b1100, 32'hAABB0000});
    checkOutput("sparse_keep_err", keep_err, 1'b0);
`else
    checkOutput("sparse_data", {keep_out, data_out}, {4'b1100, 32'hAA110000});
    checkOutput("sparse_keep_err", keep_err, 1'b1);
`endif

    // Reset mid-packet with two residue bytes.
    applyStimulus(32'h33440000, 4'b1100, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("midreset_outputs", {valid_out, last_out, keep_err, keep_out, data_out}, 64'h0);
    checkOutput("midreset_ready_in", ready_in, 1'b1);
    applyStimulus(32'h55667788, 4'b1111, 1'b1);
    checkOutput("midreset_beat", {last_out, keep_out, data_out}, {1'b1, 4'b1111, 32'h55667788});

    // Randomized traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
`ifdef AXIS_PACKER_SPARSE_KEEP_EN
      k = NB'($urandom);
`else
      if ($urandom_range(0, 9) == 0) begin
        k = NB'($urandom);
      end else begin
        cnt = $urandom_range(0, NB);
        k = '0;
        for (int j = 0; j < cnt; j++) k[NB - 1 - j] = 1'b1;
      end
`endif
      applyStimulus($urandom, k, (i == 399) || ($urandom_range(0, 3) == 0));
    end

    rand_ready = 1'b0;
    @(posedge clk);
    #2 ready_out = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #2;
    checkOutput("drain_expected_beats", exp_q.size(), 0);
    checkOutput("drain_model_bytes", byte_q.size(), 0);
    checkOutput("drain_valid_out", valid_out, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
